// File: rtl/test_sequencer_pkg.sv
// Shared widths, packet layout, test-type constants and FSM state encoding for the memory test sequencer.
package test_sequencer_pkg;

    localparam int ADDR_W        = 24;
    localparam int AMM_BURST_W   = 8;
    localparam int BYTE_ADDR_W   = 2;
    localparam int BYTE_PER_WORD = 4;

    // Galois taps for x^24 + x^23 + x^22 + x^17 + 1 (maximal length, right-shifting form).
    localparam logic [ADDR_W-1:0] LFSR_TAPS = 24'hE1_0000;

    typedef logic [1:0] test_mode_type;

    localparam test_mode_type READ_ONLY  = 2'd0;
    localparam test_mode_type WRITE_ONLY = 2'd1;
    localparam test_mode_type WRITE_READ = 2'd2;

    localparam logic ADDR_MODE_SEQ = 1'b0;
    localparam logic ADDR_MODE_RND = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_WR,
        ST_SWITCH,
        ST_RUN_RD,
        ST_FLUSH,
        ST_DONE
    } seq_state_type;

    typedef struct packed {
        logic [ADDR_W-1:0]      word_address;
        logic [AMM_BURST_W-1:0] high_burst_bits;
        logic [BYTE_ADDR_W-1:0] low_burst_bits;
        logic [BYTE_ADDR_W-1:0] start_offset;
        logic [BYTE_ADDR_W-1:0] end_offset;
    } trans_struct_type;

    function automatic logic [ADDR_W-1:0] lfsr_step(input logic [ADDR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/test_sequencer_addr_gen.sv
// Address generator: sequential stride counter or Galois LFSR, reloadable from a seed.
// The register holds the address of the packet currently offered; it moves only on load/advance.
module test_sequencer_addr_gen
    import test_sequencer_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic [ADDR_W-1:0]      seed,
    input  logic                   advance,
    input  logic                   mode,
    input  logic [AMM_BURST_W-1:0] stride,
    output logic [ADDR_W-1:0]      addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] seed_fix;
    logic [ADDR_W-1:0] step_val;

    always_comb begin
        seed_fix = seed;
        // An all-zero LFSR state never leaves zero, so a zero seed starts at 1.
        if (mode == ADDR_MODE_RND && seed == '0) begin
            seed_fix = ADDR_W'(1);
        end

        if (mode == ADDR_MODE_RND) begin
            step_val = lfsr_step(addr_q);
        end else begin
            step_val = addr_q + ADDR_W'(stride) + ADDR_W'(1);
        end

        addr_d = addr_q;
        if (load) begin
            addr_d = seed_fix;
        end else if (advance) begin
            addr_d = step_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/test_sequencer.sv
// Memory test controller: on start emits write/read op packets over a valid/ready handshake,
// tracks completion/abort and reports busy/done/error/count. op_valid is held with a stable packet until accepted.
module test_sequencer
    import test_sequencer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_start_i,
    input  logic                  test_abort_i,
    input  logic [0:3][31:0]      test_param_reg_i,
    input  logic                  op_ready_i,
    input  logic                  trans_busy_i,
    input  logic                  cmp_busy_i,
    input  logic                  error_check_i,
    output logic                  op_valid_o,
    output logic                  op_type_o,
    output trans_struct_type      op_pkt_struct_o,
    output logic                  test_busy_o,
    output logic                  test_done_o,
    output logic                  test_error_o,
    output logic [31:0]           op_cnt_o
);

    seq_state_type          state_q, state_d;
    logic                   op_valid_q, op_valid_d;
    logic                   op_type_q, op_type_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [31:0]            op_cnt_q, op_cnt_d;
    logic [AMM_BURST_W-1:0] burst_q, burst_d;
    test_mode_type          type_q, type_d;
    logic                   mode_q, mode_d;
    logic [31:0]            count_q, count_d;
    logic [ADDR_W-1:0]      seed_q, seed_d;
    logic [BYTE_ADDR_W-1:0] end_ofs_q, end_ofs_d;

    logic                   ag_load;
    logic                   ag_advance;
    logic                   ag_mode;
    logic [ADDR_W-1:0]      ag_seed;
    logic [ADDR_W-1:0]      ag_addr;

    logic                   xfer;
    logic                   last_xfer;
    logic [31:0]            op_cnt_inc;
    logic                   unused_bits;

    assign unused_bits = ^{test_param_reg_i[1], test_param_reg_i[0][31:21],
                           test_param_reg_i[0][19:18], test_param_reg_i[0][15:AMM_BURST_W],
                           test_param_reg_i[3][31:ADDR_W]};

    assign xfer       = op_valid_q && op_ready_i;
    assign last_xfer  = (op_cnt_q == count_q - 32'd1);
    assign op_cnt_inc = (op_cnt_q == '1) ? op_cnt_q : op_cnt_q + 32'd1;

    // While idle the generator must be loaded from the live CSR values; later reloads use the latched copy.
    assign ag_mode = (state_q == ST_IDLE) ? test_param_reg_i[0][20]           : mode_q;
    assign ag_seed = (state_q == ST_IDLE) ? test_param_reg_i[3][ADDR_W-1:0]   : seed_q;

    test_sequencer_addr_gen u_addr_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (ag_load),
        .seed    (ag_seed),
        .advance (ag_advance),
        .mode    (ag_mode),
        .stride  (burst_q),
        .addr    (ag_addr)
    );

    always_comb begin
        state_d    = state_q;
        op_valid_d = op_valid_q;
        op_type_d  = op_type_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        op_cnt_d   = op_cnt_q;
        burst_d    = burst_q;
        type_d     = type_q;
        mode_d     = mode_q;
        count_d    = count_q;
        seed_d     = seed_q;
        end_ofs_d  = end_ofs_q;
        ag_load    = 1'b0;
        ag_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (test_start_i) begin
                    burst_d   = test_param_reg_i[0][AMM_BURST_W-1:0];
                    type_d    = test_param_reg_i[0][17:16];
                    mode_d    = test_param_reg_i[0][20];
                    count_d   = test_param_reg_i[2];
                    seed_d    = test_param_reg_i[3][ADDR_W-1:0];
                    end_ofs_d = BYTE_ADDR_W'(BYTE_PER_WORD - 1);
                    op_cnt_d  = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    ag_load   = 1'b1;
                    if (test_param_reg_i[0][17:16] == 2'd3) begin
                        error_d = 1'b1;
                        state_d = ST_FLUSH;
                    end else if (test_param_reg_i[2] == '0) begin
                        state_d = ST_FLUSH;
                    end else if (test_param_reg_i[0][17:16] == READ_ONLY) begin
                        state_d    = ST_RUN_RD;
                        op_valid_d = 1'b1;
                        op_type_d  = 1'b1;
                    end else begin
                        state_d    = ST_RUN_WR;
                        op_valid_d = 1'b1;
                        op_type_d  = 1'b0;
                    end
                end
            end

            ST_RUN_WR, ST_RUN_RD: begin
                if (xfer) begin
                    op_cnt_d   = op_cnt_inc;
                    ag_advance = 1'b1;
                    if (last_xfer) begin
                        op_valid_d = 1'b0;
                        if (state_q == ST_RUN_RD || type_q == WRITE_ONLY) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_SWITCH;
                        end
                    end
                end
            end

            ST_SWITCH: begin
                // Read-back starts only once the write traffic has fully drained.
                if (!trans_busy_i && op_ready_i) begin
                    ag_load    = 1'b1;
                    op_cnt_d   = '0;
                    op_valid_d = 1'b1;
                    op_type_d  = 1'b1;
                    state_d    = ST_RUN_RD;
                end
            end

            ST_FLUSH: begin
                if (!trans_busy_i && !cmp_busy_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mismatch or abort withdraws any offered packet and drains; only a mismatch marks error.
        if (state_q != ST_IDLE && (error_check_i || test_abort_i)) begin
            if (error_check_i) begin
                error_d = 1'b1;
            end
            op_valid_d = 1'b0;
            ag_load    = 1'b0;
            done_d     = done_q;
            busy_d     = busy_q;
            state_d    = ST_FLUSH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_valid_q <= 1'b0;
            op_type_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            op_cnt_q   <= '0;
            burst_q    <= '0;
            type_q     <= READ_ONLY;
            mode_q     <= ADDR_MODE_SEQ;
            count_q    <= '0;
            seed_q     <= '0;
            end_ofs_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_valid_q <= op_valid_d;
            op_type_q  <= op_type_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            op_cnt_q   <= op_cnt_d;
            burst_q    <= burst_d;
            type_q     <= type_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            seed_q     <= seed_d;
            end_ofs_q  <= end_ofs_d;
        end
    end

    always_comb begin
        op_pkt_struct_o                 = '0;
        op_pkt_struct_o.word_address    = ag_addr;
        op_pkt_struct_o.high_burst_bits = burst_q;
        op_pkt_struct_o.end_offset      = end_ofs_q;
    end

    assign op_valid_o   = op_valid_q;
    assign op_type_o    = op_type_q;
    assign test_busy_o  = busy_q;
    assign test_done_o  = done_q;
    assign test_error_o = error_q;
    assign op_cnt_o     = op_cnt_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: each task drives one scenario and checks hand-computed results.
module tb_test_sequencer;
    import test_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic test_start = 1'b0;
    logic test_abort = 1'b0;
    logic op_ready = 1'b0;
    logic trans_busy = 1'b0;
    logic cmp_busy = 1'b0;
    logic error_check = 1'b0;
    logic [0:3][31:0] params = '0;

    logic             op_valid;
    logic             op_type;
    trans_struct_type pkt;
    logic             test_busy;
    logic             test_done;
    logic             test_error;
    logic [31:0]      op_cnt;

    int n_checks = 0;
    int n_pass = 0;

    logic [ADDR_W-1:0] cap_addr[$];
    logic              cap_type[$];

    always #5 clk = ~clk;

    test_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .test_start_i     (test_start),
        .test_abort_i     (test_abort),
        .test_param_reg_i (params),
        .op_ready_i       (op_ready),
        .trans_busy_i     (trans_busy),
        .cmp_busy_i       (cmp_busy),
        .error_check_i    (error_check),
        .op_valid_o       (op_valid),
        .op_type_o        (op_type),
        .op_pkt_struct_o  (pkt),
        .test_busy_o      (test_busy),
        .test_done_o      (test_done),
        .test_error_o     (test_error),
        .op_cnt_o         (op_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input logic [31:0] r0, input logic [31:0] r2, input logic [31:0] r3);
        params[0] = r0;
        params[2] = r2;
        params[3] = r3;
        test_start = 1'b1;
        step();
        test_start = 1'b0;
    endtask

    task automatic collect(input int budget, output bit finished);
        finished = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (test_done) begin
                finished = 1'b1;
                break;
            end
            if (op_valid && op_ready) begin
                cap_addr.push_back(pkt.word_address);
                cap_type.push_back(op_type);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({op_valid, op_type, test_busy, test_done, test_error} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {op_valid, op_type, test_busy, test_done, test_error});
        else n_pass++;
        n_checks++;
        if (pkt !== '0) $display("FAIL reset_pkt got=%h exp=0", pkt);
        else n_pass++;
        n_checks++;
        if (op_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", op_cnt);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_only();
        logic [ADDR_W-1:0] exp_a [4];
        bit fin;
        exp_a[0] = 24'h10; exp_a[1] = 24'h14; exp_a[2] = 24'h18; exp_a[3] = 24'h1C;
        cap_addr.delete(); cap_type.delete();
        op_ready = 1'b1;
        start_test(32'h0001_0003, 32'd4, 32'h10);
        n_checks++;
        if (pkt.high_burst_bits !== 8'd3 || pkt.end_offset !== 2'd3 || pkt.start_offset !== 2'd0 || pkt.low_burst_bits !== 2'd0)
            $display("FAIL wo_pkt_fields got=%h exp burst=3 end=3 start=0 low=0", pkt);
        else n_pass++;
        collect(60, fin);
        n_checks++;
        if (!fin) $display("FAIL wo_finish got=done0 exp=done1");
        else n_pass++;
        n_checks++;
        if (cap_addr.size() !== 4) $display("FAIL wo_nops got=%0d exp=4", cap_addr.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_a[i] || cap_type[i] !== 1'b0)
                $display("FAIL wo_op%0d got=%h/%b exp=%h/0", i, cap_addr[i], cap_type[i], exp_a[i]);
            else n_pass++;
        end
        n_checks++;
        if ({test_done, test_busy, test_error} !== 3'b100 || op_cnt !== 32'd4)
            $display("FAIL wo_status got=dbe%b cnt=%0d exp=dbe100 cnt=4", {test_done, test_busy, test_error}, op_cnt);
        else n_pass++;
    endtask

    task automatic test_write_read_rnd();
        logic [ADDR_W-1:0] exp_a [6];
        int hold;
        bit bad_hold;
        bit fin;
        exp_a[0] = 24'h00_0001; exp_a[1] = 24'hE1_0000; exp_a[2] = 24'h70_8000;
        exp_a[3] = 24'h00_0001; exp_a[4] = 24'hE1_0000; exp_a[5] = 24'h70_8000;
        cap_addr.delete(); cap_type.delete();
        op_ready = 1'b1;
        trans_busy = 1'b1;
        hold = 0; bad_hold = 1'b0; fin = 1'b0;
        start_test(32'h0012_0000, 32'd3, 32'h0);
        for (int c = 0; c < 100; c++) begin
            if (test_done) begin
                fin = 1'b1;
                break;
            end
            if (cap_addr.size() == 3 && hold < 6) begin
                hold++;
                if (op_valid) bad_hold = 1'b1;
            end else if (cap_addr.size() >= 3) begin
                trans_busy = 1'b0;
            end
            if (op_valid && op_ready) begin
                cap_addr.push_back(pkt.word_address);
                cap_type.push_back(op_type);
            end
            step();
        end
        trans_busy = 1'b0;
        n_checks++;
        if (!fin || bad_hold) $display("FAIL wr_switch_hold got=fin%b bad%b exp=fin1 bad0", fin, bad_hold);
        else n_pass++;
        n_checks++;
        if (cap_addr.size() !== 6) $display("FAIL wr_nops got=%0d exp=6", cap_addr.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_a[i] || cap_type[i] !== (i >= 3))
                $display("FAIL wr_op%0d got=%h/%b exp=%h/%b", i, cap_addr[i], cap_type[i], exp_a[i], i >= 3);
            else n_pass++;
        end
        n_checks++;
        if (op_cnt !== 32'd3 || test_error !== 1'b0)
            $display("FAIL wr_status got=cnt%0d err%b exp=cnt3 err0", op_cnt, test_error);
        else n_pass++;
    endtask

    task automatic test_stall();
        trans_struct_type snap;
        bit unstable;
        bit fin;
        cap_addr.delete(); cap_type.delete();
        op_ready = 1'b0;
        start_test(32'h0001_0000, 32'd2, 32'h100);
        snap = pkt;
        unstable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!op_valid || pkt !== snap || op_cnt !== 32'd0) unstable = 1'b1;
            params[0] = 32'h0002_00FF;
            step();
        end
        n_checks++;
        if (unstable || snap.word_address !== 24'h100)
            $display("FAIL stall_hold got=unstable%b addr=%h exp=unstable0 addr=100", unstable, snap.word_address);
        else n_pass++;
        op_ready = 1'b1;
        step();
        n_checks++;
        if (op_cnt !== 32'd1 || !op_valid || pkt.word_address !== 24'h101)
            $display("FAIL stall_xfer got=cnt%0d v%b a=%h exp=cnt1 v1 a=101", op_cnt, op_valid, pkt.word_address);
        else n_pass++;
        collect(30, fin);
        n_checks++;
        if (!fin || op_cnt !== 32'd2 || pkt.high_burst_bits !== 8'd0)
            $display("FAIL stall_done got=fin%b cnt%0d burst%0d exp=fin1 cnt2 burst0", fin, op_cnt, pkt.high_burst_bits);
        else n_pass++;
    endtask

    task automatic test_error_abort();
        int got;
        bit fin;
        op_ready = 1'b1;
        got = 0;
        start_test(32'h0001_0000, 32'd8, 32'h0);
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (op_valid && op_ready) got++;
            step();
        end
        op_ready = 1'b0;
        error_check = 1'b1;
        step();
        error_check = 1'b0;
        n_checks++;
        if (op_valid !== 1'b0 || op_cnt !== 32'd2 || test_error !== 1'b1)
            $display("FAIL err_withdraw got=v%b cnt%0d e%b exp=v0 cnt2 e1", op_valid, op_cnt, test_error);
        else n_pass++;
        collect(20, fin);
        n_checks++;
        if (!fin || test_error !== 1'b1 || op_cnt !== 32'd2 || test_busy !== 1'b0)
            $display("FAIL err_done got=fin%b e%b cnt%0d b%b exp=fin1 e1 cnt2 b0", fin, test_error, op_cnt, test_busy);
        else n_pass++;

        op_ready = 1'b1;
        start_test(32'h0001_0000, 32'd8, 32'h0);
        step();
        test_abort = 1'b1;
        step();
        test_abort = 1'b0;
        n_checks++;
        if (op_valid !== 1'b0 || test_error !== 1'b0)
            $display("FAIL abort_withdraw got=v%b e%b exp=v0 e0", op_valid, test_error);
        else n_pass++;
        collect(20, fin);
        n_checks++;
        if (!fin || test_error !== 1'b0) $display("FAIL abort_done got=fin%b e%b exp=fin1 e0", fin, test_error);
        else n_pass++;

        error_check = 1'b1;
        test_abort = 1'b1;
        step();
        error_check = 1'b0;
        test_abort = 1'b0;
        step();
        n_checks++;
        if (test_error !== 1'b0 || test_done !== 1'b1 || test_busy !== 1'b0)
            $display("FAIL idle_ignore got=e%b d%b b%b exp=e0 d1 b0", test_error, test_done, test_busy);
        else n_pass++;

        start_test(32'h0001_0000, 32'd8, 32'h0);
        test_abort = 1'b1;
        error_check = 1'b1;
        step();
        test_abort = 1'b0;
        error_check = 1'b0;
        collect(20, fin);
        n_checks++;
        if (!fin || test_error !== 1'b1) $display("FAIL abort_err_both got=fin%b e%b exp=fin1 e1", fin, test_error);
        else n_pass++;
    endtask

    task automatic test_zero_and_illegal();
        bit saw;
        bit fin;
        saw = 1'b0; fin = 1'b0;
        start_test(32'h0001_0000, 32'd0, 32'h20);
        for (int c = 0; c < 3; c++) begin
            if (op_valid) saw = 1'b1;
            if (test_done) begin
                fin = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (saw || !fin || test_error !== 1'b0 || op_cnt !== 32'd0)
            $display("FAIL zero_count got=saw%b fin%b e%b cnt%0d exp=saw0 fin1 e0 cnt0", saw, fin, test_error, op_cnt);
        else n_pass++;

        saw = 1'b0; fin = 1'b0;
        start_test(32'h0003_0000, 32'd5, 32'h20);
        for (int c = 0; c < 3; c++) begin
            if (op_valid) saw = 1'b1;
            if (test_done) begin
                fin = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (saw || !fin || test_error !== 1'b1)
            $display("FAIL illegal_type got=saw%b fin%b e%b exp=saw0 fin1 e1", saw, fin, test_error);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit fin;
        op_ready = 1'b1;
        start_test(32'h0000_0000, 32'd10, 32'h0);
        step(); step(); step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({op_valid, op_type, test_busy, test_done, test_error} !== 5'b0 || pkt !== '0 || op_cnt !== 32'd0)
            $display("FAIL midrst_outputs got=%b pkt=%h cnt=%0d exp=00000 pkt=0 cnt=0",
                     {op_valid, op_type, test_busy, test_done, test_error}, pkt, op_cnt);
        else n_pass++;
        rst = 1'b0;
        step();
        cap_addr.delete(); cap_type.delete();
        start_test(32'h0001_0001, 32'd2, 32'h40);
        collect(30, fin);
        n_checks++;
        if (!fin || cap_addr.size() !== 2 || op_cnt !== 32'd2)
            $display("FAIL midrst_rerun got=fin%b n%0d cnt%0d exp=fin1 n2 cnt2", fin, cap_addr.size(), op_cnt);
        else n_pass++;
        n_checks++;
        if (cap_addr.size() < 2 || cap_addr[0] !== 24'h40 || cap_addr[1] !== 24'h42)
            $display("FAIL midrst_addrs got=n%0d exp=40,42", cap_addr.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit fin;
        cap_addr.delete(); cap_type.delete();
        op_ready = 1'b0;
        test_abort = 1'b1;
        start_test(32'h0000_0003, 32'd2, 32'h00FF_FFFC);
        test_abort = 1'b0;
        n_checks++;
        if (test_busy !== 1'b1 || op_valid !== 1'b1 || test_done !== 1'b0 || op_type !== 1'b1)
            $display("FAIL b2b_start_wins got=b%b v%b d%b t%b exp=b1 v1 d0 t1", test_busy, op_valid, test_done, op_type);
        else n_pass++;
        start_test(32'h0003_0000, 32'd9, 32'h5);
        n_checks++;
        if (op_valid !== 1'b1 || pkt.word_address !== 24'hFF_FFFC || test_error !== 1'b0 || pkt.high_burst_bits !== 8'd3)
            $display("FAIL b2b_busy_start got=v%b a=%h e%b exp=v1 a=fffffc e0", op_valid, pkt.word_address, test_error);
        else n_pass++;
        op_ready = 1'b1;
        collect(30, fin);
        n_checks++;
        if (!fin || cap_addr.size() !== 2 || op_cnt !== 32'd2 || test_error !== 1'b0)
            $display("FAIL b2b_done got=fin%b n%0d cnt%0d e%b exp=fin1 n2 cnt2 e0", fin, cap_addr.size(), op_cnt, test_error);
        else n_pass++;
        n_checks++;
        if (cap_addr.size() < 2 || cap_addr[0] !== 24'hFF_FFFC || cap_addr[1] !== 24'h00_0000 || cap_type[1] !== 1'b1)
            $display("FAIL b2b_wrap got=n%0d exp=fffffc,000000 reads", cap_addr.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_write_read_rnd();
        test_stall();
        test_error_abort();
        test_zero_and_illegal();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
